// File: rtl/pit_config_arbiter.sv
// Round-robin owner of the PIT config port: grants one requester, writes cfg/count-hi/count-lo, then pulses done.
// Latency: strobes 1..3 cycles after grant, done at +4; other requests wait (busy) until the FSM returns to IDLE.
module pit_config_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [8*NUM_REQ-1:0]  cfg_byte,
  input  logic [16*NUM_REQ-1:0] count,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic                  pit_we,
  output logic [1:0]            pit_addr,
  output logic [7:0]            pit_data,
  input  logic                  pit_irq,
  output logic [NUM_REQ-1:0]    irq_out,
  output logic [1:0]            owner,
  output logic                  owner_valid
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [2:0] {IDLE, WR_CFG, WR_HI, WR_LO, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  last;
  logic [1:0]  gnt_idx;
  logic [1:0]  win;
  logic        found;
  logic [IW-1:0] cand;
  logic [7:0]  hold_cfg;
  logic [15:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Scan starts one past the last completed owner so every requester gets a turn.
  always_comb begin
    state_nxt = state;
    win       = 2'b00;
    found     = 1'b0;
    cand      = '0;
    case (state)
      IDLE: begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = IW'((int'(last) + k) % NUM_REQ);
          if (!found && req[cand]) begin
            found = 1'b1;
            win   = 2'(cand);
          end
        end
        if (found) state_nxt = WR_CFG;
      end
      WR_CFG:  state_nxt = WR_HI;
      WR_HI:   state_nxt = WR_LO;
      WR_LO:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      pit_we      <= 1'b0;
      pit_addr    <= 2'b00;
      pit_data    <= 8'h00;
      done        <= '0;
      owner       <= 2'b00;
      owner_valid <= 1'b0;
      last        <= 2'(NUM_REQ - 1);
      gnt_idx     <= 2'b00;
      hold_cfg    <= 8'h00;
      hold_cnt    <= 16'h0000;
    end else begin
      busy     <= (state_nxt != IDLE);
      pit_we   <= 1'b0;
      pit_addr <= 2'b00;
      pit_data <= 8'h00;
      done     <= '0;
      case (state)
        IDLE: begin
          // Setup data is frozen here; later input changes cannot corrupt the sequence.
          if (found) begin
            gnt_idx  <= win;
            hold_cfg <= cfg_byte[8*win +: 8];
            hold_cnt <= count[16*win +: 16];
          end
        end
        WR_CFG: begin
          pit_we   <= 1'b1;
          pit_addr <= 2'b00;
          pit_data <= hold_cfg;
        end
        WR_HI: begin
          pit_we   <= 1'b1;
          pit_addr <= 2'b01;
          pit_data <= hold_cnt[15:8];
        end
        WR_LO: begin
          pit_we   <= 1'b1;
          pit_addr <= 2'b10;
          pit_data <= hold_cnt[7:0];
        end
        DONE: begin
          done        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;
          owner       <= gnt_idx;
          owner_valid <= 1'b1;
          last        <= gnt_idx;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    irq_out = '0;
    for (int i = 0; i < NUM_REQ; i++)
      irq_out[i] = pit_irq & owner_valid & (owner == 2'(i));
  end

endmodule
